// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the initiator and its helpers.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_init_wdog.sv
// Wait-state watchdog: flags a data phase stalled for TIMEOUT_CYCLES cycles.
// Only present when AHB_INIT_TIMEOUT_EN is defined.
`ifdef AHB_INIT_TIMEOUT_EN
module ahb_init_wdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_valid,
   input  logic hready,
   input  logic timeout_clr,
   output logic timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   // Counter saturates at the limit so a very long stall cannot wrap it.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (hready || !d_valid) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (d_valid && !hready && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
         timeout_d = 1'b1;
      end
      if (timeout_clr) begin
         timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;

endmodule
`endif

// File: rtl/ahb_lite_initiator.sv
// Single-master AHB-Lite initiator: valid/ready commands in, pipelined single transfers out.
// Optional wait-state watchdog enabled with AHB_INIT_TIMEOUT_EN.
module ahb_lite_initiator
   import ahb_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [1:0]    cmd_size,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
`ifdef AHB_INIT_TIMEOUT_EN
   input  logic          timeout_clr,
   output logic          timeout,
`endif
   output logic [AW-1:0] HADDR,
   output logic [1:0]    HTRANS,
   output logic          HWRITE,
   output logic [2:0]    HSIZE,
   output logic [2:0]    HBURST,
   output logic [DW-1:0] HWDATA,
   input  logic          HREADY,
   input  logic          HRESP,
   input  logic [DW-1:0] HRDATA
);

   logic          a_valid_q, a_valid_d;
   logic [AW-1:0] a_addr_q,  a_addr_d;
   logic          a_write_q, a_write_d;
   logic [1:0]    a_size_q,  a_size_d;
   logic [DW-1:0] a_wdata_q, a_wdata_d;
   logic          d_valid_q, d_valid_d;
   logic          d_write_q, d_write_d;
   logic [DW-1:0] d_wdata_q, d_wdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q,   rsp_err_d;

   // A free address slot may be filled during a wait state: the bus shows
   // IDLE there, and IDLE may change to NONSEQ while HREADY is low.
   assign cmd_ready = ~a_valid_q | HREADY;

   always_comb begin
      a_valid_d   = a_valid_q;
      a_addr_d    = a_addr_q;
      a_write_d   = a_write_q;
      a_size_d    = a_size_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_write_d   = d_write_q;
      d_wdata_d   = d_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (HREADY) begin
         if (d_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = (HRESP == HRESP_ERROR);
            rsp_rdata_d = d_write_q ? '0 : HRDATA;
         end
         d_valid_d = a_valid_q;
         d_write_d = a_write_q;
         d_wdata_d = a_wdata_q;
         a_valid_d = cmd_valid;
      end
      if (cmd_valid && cmd_ready) begin
         a_valid_d = 1'b1;
         a_addr_d  = cmd_addr;
         a_write_d = cmd_write;
         a_size_d  = cmd_size;
         a_wdata_d = cmd_wdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid_q   <= 1'b0;
         a_addr_q    <= '0;
         a_write_q   <= 1'b0;
         a_size_q    <= '0;
         a_wdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         d_wdata_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         a_valid_q   <= a_valid_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         d_wdata_q   <= d_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = a_addr_q;
   assign HWRITE    = a_write_q;
   assign HSIZE     = {1'b0, a_size_q};
   assign HBURST    = HBURST_SINGLE;
   assign HWDATA    = d_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = a_valid_q | d_valid_q;

`ifdef AHB_INIT_TIMEOUT_EN
   ahb_init_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .d_valid    (d_valid_q),
      .hready     (HREADY),
      .timeout_clr(timeout_clr),
      .timeout    (timeout)
   );
`endif

endmodule

// File: doc/ahb_lite_initiator.md
Name: ahb_lite_initiator

Overview:
- Single-master AHB-Lite initiator. Turns a simple valid/ready command stream into AHB-Lite single transfers.
- Used by boot and clock-control sequencing logic to program memory-mapped register slaves, e.g. the PLL/clock control registers, without a CPU.
- Address and data phases are pipelined, so back-to-back commands issue one transfer per cycle when HREADY is high.
- Read data and error status come back on a registered response pulse.

Parameters:
- AW, 32, HADDR / cmd_addr width.
- DW, 32, HWDATA / HRDATA / cmd_wdata / rsp_rdata width.
- TIMEOUT_CYCLES, 1024, wait-state limit; used only with AHB_INIT_TIMEOUT_EN.

Ports:
- HCLK  in  1  bus clock; single clock domain.
- HRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address.
- cmd_size  in  2  log2 bytes (0/1/2), copied to HSIZE[1:0].
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_rdata  out  DW  captured HRDATA (0 for writes).
- rsp_err  out  1  HRESP was ERROR at completion.
- busy  out  1  address or data phase outstanding.
- HADDR  out  AW
- HTRANS  out  2
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  constant 3'b000 (SINGLE).
- HWDATA  out  DW
- HREADY  in  1
- HRESP  in  1
- HRDATA  in  DW

Behaviour:
- Internal state:
  - Address-phase register set a_valid/a_addr/a_write/a_size/a_wdata.
  - Data-phase register set d_valid/d_write/d_wdata.
  - All flops use the asynchronous, active-low HRESETn.
- Bus outputs:
  - HTRANS = a_valid ? 2'b10 (NONSEQ) : 2'b00 (IDLE). SEQ and BUSY are never driven.
  - HADDR/HWRITE/HSIZE come from the a_* registers.
  - HSIZE = {1'b0, a_size}.
  - HWDATA = d_wdata.
- Reset values: all registers 0. HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- cmd_ready = ~a_valid | HREADY. It is combinational on HREADY, and there is no other combinational path from inputs.
- At posedge with HREADY=1:
  - If d_valid: rsp_valid<=1, rsp_err<=HRESP, rsp_rdata <= d_write ? 0 : HRDATA.
  - Advance: d_valid<=a_valid, d_write<=a_write, d_wdata<=a_wdata.
  - a_* <= the command if cmd_valid, else a_valid<=0.
- At posedge with HREADY=0:
  - Hold all a_* and d_* registers; address and control stay stable during wait states.
  - rsp_valid<=0.
- Latency, zero-wait slave: command accepted at edge N; address phase N..N+1; data phase N+1..N+2; rsp_valid high in cycle N+2..N+3. Throughput is 1 command/cycle.
- Error response:
  - The first ERROR cycle (HRESP=1, HREADY=0) is treated as a wait state.
  - The pending address phase is not cancelled; it proceeds after the second ERROR cycle.
  - rsp_err=1 for the failed transfer only.
- No response backpressure; the consumer must accept every rsp_valid pulse.
- busy = a_valid | d_valid.
- cmd_addr alignment is not checked; the command is passed through as given.
- Reset mid-transfer: registers clear immediately, HTRANS goes IDLE, and no response is issued for in-flight transfers.

Optional Feature:
- Macro: AHB_INIT_TIMEOUT_EN.
- With the macro defined:
  - A counter tracks consecutive HREADY=0 cycles while d_valid=1.
  - When the counter reaches TIMEOUT_CYCLES, it sets a sticky output timeout (1 bit).
  - timeout is cleared by input timeout_clr (1 bit) or by reset.
  - The counter resets on HREADY=1. Bus behaviour is unchanged; the bus is never abandoned.
- Without the macro: the ports, counter and parameter use are absent.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE codes BYTE/HALF/WORD.
  - HBURST_SINGLE.
  - HRESP_OKAY/HRESP_ERROR.
- One natural sub-module: ahb_init_wdog, the timeout counter, instantiated only under AHB_INIT_TIMEOUT_EN.

Test Plan:
- Write with zero-wait slave:
  - Stimulus: cmd write addr 0x4000_0008, data 0x0000_0005, size 2, accepted edge N.
  - Required: HTRANS=2'b10, HADDR=0x4000_0008, HWRITE=1, HSIZE=3'b010 in cycle N+1.
  - Required: HWDATA=0x5 in cycle N+2, rsp_valid=1 with rsp_err=0 in cycle N+3.
- Read with 2 wait states:
  - Stimulus: read 0x4000_0000; slave holds HREADY=0 for 2 cycles, then HRDATA=0xDEAD_BEEF.
  - Required: rsp_rdata=0xDEAD_BEEF exactly 2 cycles later than the zero-wait case.
  - Required: HADDR stable throughout.
- Back-to-back:
  - Stimulus: 4 writes to 0x00/0x04/0x08/0x00 with cmd_valid held high.
  - Required: cmd_ready=1 every cycle, 4 consecutive NONSEQ cycles, 4 consecutive rsp_valid pulses.
- Error:
  - Stimulus: slave returns a two-cycle ERROR on the 2nd of 3 reads.
  - Required: rsp_err sequence 0,1,0; the 3rd transfer still completes.
- Reset mid-operation:
  - Stimulus: assert HRESETn=0 during a data phase.
  - Required: HTRANS=IDLE and busy=0 immediately; no rsp_valid; next command after release runs normally.
- Timeout (AHB_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: HREADY low for 8 cycles.
  - Required: timeout=1 and it stays 1 until timeout_clr pulse.
